// File: rtl/decode_ctrl_stage.sv
// Decode/control register stage: classifies the opcode, extracts register
// indices and the sign-extended immediate, and presents them one cycle later
// behind a valid/ready handshake with a load-use interlock and a flush.
module decode_ctrl_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      ALUOp,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            ALUSrc,
  output logic            illegal
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  // Registered bundle
  logic            out_valid_q, out_valid_d;
  logic [1:0]      aluop_q, aluop_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q, memread_d;
  logic            memwrite_q, memwrite_d;
  logic            branch_q, branch_d;
  logic            alusrc_q, alusrc_d;
  logic            illegal_q, illegal_d;

  // Decoded view of the incoming instruction
  logic [1:0]      dec_aluop;
  logic [6:0]      dec_funct7;
  logic [XLEN-1:0] dec_imm;
  logic            dec_regwrite, dec_memread, dec_memwrite, dec_branch, dec_alusrc;
  logic            dec_illegal;
  logic            uses_rs1, uses_rs2;
  logic            hazard;
  logic            accept;

  // Opcode classification, control enables and immediate formation
  always_comb begin
    dec_aluop    = 2'b00;
    dec_funct7   = 7'b0;
    dec_imm      = '0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_alusrc   = 1'b0;
    dec_illegal  = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    unique case (instr[6:0])
      OpR: begin
        dec_aluop    = 2'b00;
        dec_regwrite = 1'b1;
        dec_funct7   = instr[31:25];
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OpI: begin
        dec_aluop    = 2'b01;
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
        uses_rs1     = 1'b1;
      end
      OpLoad: begin
        dec_aluop    = 2'b10;
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        dec_alusrc   = 1'b1;
        dec_imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
        uses_rs1     = 1'b1;
      end
      OpStore: begin
        dec_aluop    = 2'b10;
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OpBranch: begin
        dec_aluop    = 2'b11;
        dec_branch   = 1'b1;
        dec_imm      = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Load-use interlock; illegal instructions never use registers so never stall
  always_comb begin
    hazard = out_valid_q && memread_q && (rd_q != 5'd0) &&
             ((uses_rs1 && (instr[19:15] == rd_q)) ||
              (uses_rs2 && (instr[24:20] == rd_q)));
    in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // Next-state: flush kills, a transfer loads, a consume without refill empties
  always_comb begin
    out_valid_d = out_valid_q;
    aluop_d     = aluop_q;
    funct3_d    = funct3_q;
    funct7_d    = funct7_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    regwrite_d  = regwrite_q;
    memread_d   = memread_q;
    memwrite_d  = memwrite_q;
    branch_d    = branch_q;
    alusrc_d    = alusrc_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      aluop_d     = dec_aluop;
      funct3_d    = instr[14:12];
      funct7_d    = dec_funct7;
      rd_d        = instr[11:7];
      rs1_d       = instr[19:15];
      rs2_d       = instr[24:20];
      imm_d       = dec_imm;
      regwrite_d  = dec_regwrite;
      memread_d   = dec_memread;
      memwrite_d  = dec_memwrite;
      branch_d    = dec_branch;
      alusrc_d    = dec_alusrc;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Bundle register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      aluop_q     <= 2'b00;
      funct3_q    <= 3'b0;
      funct7_q    <= 7'b0;
      rd_q        <= 5'b0;
      rs1_q       <= 5'b0;
      rs2_q       <= 5'b0;
      imm_q       <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      alusrc_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      aluop_q     <= aluop_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      branch_q    <= branch_d;
      alusrc_q    <= alusrc_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALUOp     = aluop_q;
  assign funct3    = funct3_q;
  assign funct7    = funct7_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign imm       = imm_q;
  assign RegWrite  = regwrite_q;
  assign MemRead   = memread_q;
  assign MemWrite  = memwrite_q;
  assign Branch    = branch_q;
  assign ALUSrc    = alusrc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage with hand-computed expectations.
module tb_decode_ctrl_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, imm;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic        RegWrite, MemRead, MemWrite, Branch, ALUSrc, illegal;

  int n_checks = 0;
  int n_pass   = 0;

  decode_ctrl_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ALUOp(ALUOp),
    .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ALUSrc(ALUSrc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-assembled instruction words
  // R: f7=0110000 rs2=3 rs1=2 f3=001 rd=1
  localparam logic [31:0] IR_A   = {7'b0110000, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0110011};
  // branch rs2=7 rs1=6 f3=000, imm=-8
  localparam logic [31:0] IBR    = {7'b1111111, 5'd7, 5'd6, 3'b000, 5'b11001, 7'b1100011};
  // I: imm=0x7FF rs1=1 f3=000 rd=4
  localparam logic [31:0] II     = {12'h7FF, 5'd1, 3'b000, 5'd4, 7'b0010011};
  // store: imm=-4 rs2=8 rs1=1 f3=010
  localparam logic [31:0] IST    = {7'b1111111, 5'd8, 5'd1, 3'b010, 5'b11100, 7'b0100011};
  // load: imm=0x10 rs1=1 f3=010 rd=5
  localparam logic [31:0] ILD5   = {12'h010, 5'd1, 3'b010, 5'd5, 7'b0000011};
  // load rd=0
  localparam logic [31:0] ILD0   = {12'h010, 5'd1, 3'b010, 5'd0, 7'b0000011};
  // R: rs2=5 rs1=2 rd=6
  localparam logic [31:0] IR_H5  = {7'b0000000, 5'd5, 5'd2, 3'b000, 5'd6, 7'b0110011};
  // R: rs2=0 rs1=2 rd=10
  localparam logic [31:0] IR_H0  = {7'b0000000, 5'd0, 5'd2, 3'b000, 5'd10, 7'b0110011};
  // illegal opcode with rs1=rs2=rd=5
  localparam logic [31:0] IILL   = {7'b0000000, 5'd5, 5'd5, 3'b000, 5'd5, 7'b1111111};

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imm", imm, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // R-type
    in_valid = 1'b1; out_ready = 1'b1; instr = IR_A;
    #1 check("r_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("r_out_valid", {31'b0, out_valid}, 32'd1);
    check("r_aluop", {30'b0, ALUOp}, 32'd0);
    check("r_funct3", {29'b0, funct3}, 32'd1);
    check("r_funct7", {25'b0, funct7}, 32'h30);
    check("r_regwrite", {31'b0, RegWrite}, 32'd1);
    check("r_alusrc", {31'b0, ALUSrc}, 32'd0);
    check("r_rd_rs1_rs2", {17'b0, rd, rs1, rs2}, {17'b0, 5'd1, 5'd2, 5'd3});
    check("r_imm", imm, 32'd0);

    // branch
    instr = IBR;
    tick();
    check("br_aluop", {30'b0, ALUOp}, 32'd3);
    check("br_branch", {31'b0, Branch}, 32'd1);
    check("br_funct7", {25'b0, funct7}, 32'd0);
    check("br_imm", imm, 32'hFFFF_FFF8);
    check("br_regwrite", {31'b0, RegWrite}, 32'd0);

    // I-type: funct7 must be zero though instr[31:25] is not
    instr = II;
    tick();
    check("i_aluop", {30'b0, ALUOp}, 32'd1);
    check("i_alusrc", {31'b0, ALUSrc}, 32'd1);
    check("i_imm", imm, 32'h0000_07FF);
    check("i_funct7", {25'b0, funct7}, 32'd0);

    // store
    instr = IST;
    tick();
    check("st_aluop", {30'b0, ALUOp}, 32'd2);
    check("st_ctrl", {28'b0, MemWrite, MemRead, RegWrite, ALUSrc}, 32'b1001);
    check("st_imm", imm, 32'hFFFF_FFFC);

    // load rd=5 then dependent R on rs2=5: one bubble
    instr = ILD5;
    tick();
    check("ld_ctrl", {28'b0, MemWrite, MemRead, RegWrite, ALUSrc}, 32'b0111);
    check("ld_imm", imm, 32'h10);
    instr = IR_H5;
    #1 check("hz_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("hz_bubble", {31'b0, out_valid}, 32'd0);
    check("hz_in_ready_after", {31'b0, in_ready}, 32'd1);
    tick();
    check("hz_accept_valid", {31'b0, out_valid}, 32'd1);
    check("hz_accept_rd", {27'b0, rd}, 32'd6);

    // load rd=0 then R on rs2=0: no bubble
    instr = ILD0;
    tick();
    instr = IR_H0;
    #1 check("nohz_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("nohz_valid", {31'b0, out_valid}, 32'd1);
    check("nohz_rd", {27'b0, rd}, 32'd10);

    // backpressure for 3 cycles
    out_ready = 1'b0; instr = II;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_fields", {17'b0, rd, rs1, rs2}, {17'b0, 5'd10, 5'd2, 5'd0});
      check("hold_regwrite", {31'b0, RegWrite}, 32'd1);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("release_rd", {27'b0, rd}, 32'd4);
    check("release_aluop", {30'b0, ALUOp}, 32'd1);

    // drain with no new input
    in_valid = 1'b0;
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // flush drops the presented instruction
    in_valid = 1'b1; instr = IR_A; flush = 1'b1;
    #1 check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_rd_kept", {27'b0, rd}, 32'd4);
    flush = 1'b0;

    // load rd=5 then illegal naming r5: no hazard, accepted as illegal
    instr = ILD5;
    tick();
    instr = IILL;
    #1 check("ill_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("ill_valid", {31'b0, out_valid}, 32'd1);
    check("ill_flag", {31'b0, illegal}, 32'd1);
    check("ill_enables", {27'b0, RegWrite, MemRead, MemWrite, Branch, ALUSrc}, 32'd0);
    check("ill_aluop", {30'b0, ALUOp}, 32'd0);
    check("ill_imm", imm, 32'd0);

    // asynchronous reset between edges while a bundle is valid
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_illegal", {31'b0, illegal}, 32'd0);
    check("arst_rd", {27'b0, rd}, 32'd0);
    check("arst_funct3", {29'b0, funct3}, 32'd0);
    rst = 1'b0;
    #1 check("arst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
